// File: rtl/screen_sequencer_pkg.sv
// screen_sequencer_pkg: shared screen/powerup encodings and limits for the game-flow sequencer
package screen_sequencer_pkg;
  typedef enum logic [2:0] {LOGO, READY, PLAY, TIMES_UP, LEADERBOARD} state_t;
  typedef enum logic [1:0] {PU_SNITCH, PU_TURNER, PU_LIGHTNING, PU_BROOM} pu_t;
  localparam int MAX_TIME = 99;
endpackage

// File: rtl/screen_sequencer_powerup.sv
// screen_sequencer_powerup: activates one powerup per period on a fixed rotation, cleared by collect or hold timeout
module screen_sequencer_powerup
  import screen_sequencer_pkg::*;
#(
  parameter int PU_PERIOD_S = 10,
  parameter int PU_HOLD_S   = 5
) (
  input  logic iVGA_CLK,
  input  logic iRST_n,
  input  logic sec_tick,
  input  logic playing,
  input  logic pu_collect,
  output logic snitch_powerup,
  output logic time_turner_powerup,
  output logic lightning_powerup,
  output logic broom_powerup
);
  pu_t        idx, idx_n;
  logic [3:0] pu_sec, pu_sec_n, hold, hold_n, flags, flags_n;
  logic       active;
  assign active = |flags;
  // playing is the sequencer's next-cycle view, so flags drop on the same edge gameplay ends
  always_comb begin
    idx_n    = idx;
    pu_sec_n = pu_sec;
    hold_n   = hold;
    flags_n  = flags;
    if (!playing) begin
      idx_n    = PU_SNITCH;
      pu_sec_n = '0;
      hold_n   = '0;
      flags_n  = '0;
    end else begin
      if (sec_tick && active) hold_n = hold + 4'd1;
      if (active && (pu_collect || (sec_tick && hold == 4'(PU_HOLD_S - 1)))) flags_n = '0;
      if (sec_tick) begin
        pu_sec_n = pu_sec + 4'd1;
        if (pu_sec == 4'(PU_PERIOD_S - 1)) begin
          pu_sec_n = '0;
          hold_n   = '0;
          flags_n  = 4'b0001 << idx;
          idx_n    = pu_t'(idx + 2'd1);
        end
      end
    end
  end
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      idx    <= PU_SNITCH;
      pu_sec <= '0;
      hold   <= '0;
      flags  <= '0;
    end else begin
      idx    <= idx_n;
      pu_sec <= pu_sec_n;
      hold   <= hold_n;
      flags  <= flags_n;
    end
  end
  assign snitch_powerup      = flags[0];
  assign time_turner_powerup = flags[1];
  assign lightning_powerup   = flags[2];
  assign broom_powerup       = flags[3];
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-counted game flow (logo, ready, play, times-up, leaderboard) with countdown and powerups
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int FPS             = 60,
  parameter int LOGO_MIN_FRAMES = 60,
  parameter int READY_FRAMES    = 180,
  parameter int GAME_SECONDS    = 60,
  parameter int TIMESUP_FRAMES  = 120,
  parameter int PU_PERIOD_S     = 10,
  parameter int PU_HOLD_S       = 5,
  parameter int TURNER_BONUS_S  = 10
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       vs_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pu_collect,
  output logic       logo,
  output logic       get_ready,
  output logic       playing,
  output logic       times_up,
  output logic       leaderboard,
  output logic       snitch_powerup,
  output logic       time_turner_powerup,
  output logic       lightning_powerup,
  output logic       broom_powerup,
  output logic [6:0] time_left,
  output logic       frame_tick
);
  state_t     state, state_n;
  logic [7:0] fcnt, fcnt_n, bonus_sum;
  logic [6:0] sec_frames, sec_frames_n, time_left_n;
  logic       vs_prev, start_prev, start_edge, sec_tick, turner_hit, play_n;
  assign start_edge = start & ~start_prev;
  assign sec_tick   = (state == PLAY) & frame_tick & (sec_frames == 7'(FPS - 1));
  assign turner_hit = pu_collect & time_turner_powerup;
  assign bonus_sum  = {1'b0, time_left} + 8'(TURNER_BONUS_S) - {7'd0, sec_tick};
  assign play_n     = state_n == PLAY;
  always_comb begin
    state_n      = state;
    fcnt_n       = fcnt;
    sec_frames_n = sec_frames;
    time_left_n  = time_left;
    if (abort) begin
      state_n      = LOGO;
      fcnt_n       = '0;
      sec_frames_n = '0;
      time_left_n  = 7'(GAME_SECONDS);
    end else begin
      case (state)
        LOGO: begin
          if (start_edge && fcnt == 8'(LOGO_MIN_FRAMES)) begin
            state_n = READY;
            fcnt_n  = '0;
          end else if (frame_tick && fcnt != 8'(LOGO_MIN_FRAMES)) fcnt_n = fcnt + 8'd1;
        end
        READY: begin
          if (frame_tick) begin
            fcnt_n = fcnt + 8'd1;
            if (fcnt == 8'(READY_FRAMES - 1)) begin
              state_n      = PLAY;
              fcnt_n       = '0;
              sec_frames_n = '0;
              time_left_n  = 7'(GAME_SECONDS);
            end
          end
        end
        PLAY: begin
          if (frame_tick) sec_frames_n = sec_tick ? '0 : sec_frames + 7'd1;
          // a turner collect absorbs a coincident second, so it can never expire the game
          if (turner_hit) time_left_n = bonus_sum > 8'(MAX_TIME) ? 7'(MAX_TIME) : bonus_sum[6:0];
          else if (sec_tick) begin
            time_left_n = time_left - 7'd1;
            if (time_left == 7'd1) begin
              state_n = TIMES_UP;
              fcnt_n  = '0;
            end
          end
        end
        TIMES_UP: begin
          if (frame_tick) begin
            fcnt_n = fcnt + 8'd1;
            if (fcnt == 8'(TIMESUP_FRAMES - 1)) begin
              state_n = LEADERBOARD;
              fcnt_n  = '0;
            end
          end
        end
        LEADERBOARD: begin
          if (start_edge) begin
            state_n = LOGO;
            fcnt_n  = '0;
          end
        end
        default: state_n = LOGO;
      endcase
    end
  end
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state       <= LOGO;
      fcnt        <= '0;
      sec_frames  <= '0;
      time_left   <= 7'(GAME_SECONDS);
      vs_prev     <= 1'b0;
      start_prev  <= 1'b0;
      frame_tick  <= 1'b0;
      logo        <= 1'b1;
      get_ready   <= 1'b0;
      playing     <= 1'b0;
      times_up    <= 1'b0;
      leaderboard <= 1'b0;
    end else begin
      state       <= state_n;
      fcnt        <= fcnt_n;
      sec_frames  <= sec_frames_n;
      time_left   <= time_left_n;
      vs_prev     <= vs_n;
      start_prev  <= start;
      frame_tick  <= ~abort & vs_prev & ~vs_n;
      logo        <= state_n == LOGO;
      get_ready   <= state_n == READY;
      playing     <= state_n == PLAY;
      times_up    <= state_n == TIMES_UP;
      leaderboard <= state_n == LEADERBOARD;
    end
  end
  screen_sequencer_powerup #(
    .PU_PERIOD_S(PU_PERIOD_S),
    .PU_HOLD_S  (PU_HOLD_S)
  ) u_powerup (
    .iVGA_CLK           (iVGA_CLK),
    .iRST_n             (iRST_n),
    .sec_tick           (sec_tick),
    .playing            (play_n),
    .pu_collect         (pu_collect),
    .snitch_powerup     (snitch_powerup),
    .time_turner_powerup(time_turner_powerup),
    .lightning_powerup  (lightning_powerup),
    .broom_powerup      (broom_powerup)
  );
endmodule
